decoder_pipe: RTL and testbench
===============================

Name: decoder_pipe

Overview:
- Parametrised, registered binary-to-one-hot / thermometer decoder with a valid/ready handshake on both sides.
- Successor to the fixed 3-to-8 combinational decoder.
- Used in the datapath for register-file write-enable selection and ALU-op select fan-out, where the decode must be retimed and must tolerate downstream back-pressure.
- Single output stage; one decode per cycle at full throughput.

Parameters:
- IN_W, 3, index width in bits.
- OUT_W, 8, output vector width; legal range 1..2**IN_W. Indices >= OUT_W are out-of-range.
- CNT_W, 16, width of the accepted-transfer counter.

Ports:
- clk_i  in  1  clock, rising edge.
- rst_n_i  in  1  asynchronous active-low reset.
- in_valid_i  in  1  input index valid.
- in_ready_o  out  1  block can accept an input this cycle.
- data_i  in  IN_W  binary index.
- mode_i  in  1  0 = one-hot, 1 = thermometer. Sampled with data_i.
- out_valid_o  out  1  registered result valid.
- out_ready_i  in  1  downstream accepts the result.
- data_o  out  OUT_W  decoded vector.
- err_o  out  1  result came from an out-of-range index. Qualified by out_valid_o.
- count_o  out  CNT_W  number of accepted inputs, modulo 2**CNT_W.

Behaviour:
- Reset (rst_n_i low, asynchronous): out_valid_o=0, data_o=0, err_o=0, count_o=0. in_ready_o is forced 0 while rst_n_i is low. Reset mid-transfer discards the held result with no residue. First accept is possible on the first rising edge after release.
- in_ready_o = rst_n_i & (!out_valid_o | out_ready_i). This is combinational, giving full throughput with a single register stage (no skid).
- Accept = in_valid_i & in_ready_o. On accept, at the next edge:
  - out_valid_o <= 1.
  - data_o <= decode(data_i, mode_i).
  - err_o <= (data_i >= OUT_W).
  - count_o <= count_o + 1, wrapping from all-ones to 0.
- Latency: exactly 1 cycle from accept to out_valid_o.
- No accept and out_ready_i=1: out_valid_o <= 0. data_o and err_o hold their last values; they are don't-care while out_valid_o=0.
- Stall (out_valid_o=1, out_ready_i=0): data_o, err_o and out_valid_o are held stable, and in_ready_o=0.
- Simultaneous drain and accept (out_valid_o=1, out_ready_i=1, in_valid_i=1): the new result replaces the old one in the same edge; out_valid_o stays 1.
- Decode, one-hot (mode 0): data_o[k] = (k == data_i).
- Decode, thermometer (mode 1): data_o[k] = (k <= data_i), so index 0 gives 1 and index OUT_W-1 gives all ones.
- Out-of-range index (data_i >= OUT_W): data_o = 0 in both modes, err_o = 1. The transfer is still consumed and counted.
- Width rules:
  - The comparison k <= data_i is unsigned and performed at IN_W+1 bits, so no truncation occurs.
  - When OUT_W == 2**IN_W, err_o is constant 0.
- in_valid_i may drop without an accept; there is no obligation to hold. data_i and mode_i matter only on the accept cycle.

Decomposition:
- Shared package decoder_pkg:
  - Mode constants DEC_ONEHOT = 1'b0 and DEC_THERMO = 1'b1.
  - Default-width localparams.
- Sub-module decoder_core: purely combinational, parametrised IN_W/OUT_W. Inputs index and mode; outputs vec and oob. It generalises the existing 3-to-8 decode.
- decoder_pipe wraps decoder_core with the handshake register and the counter.

Test Plan:
- Reset/basic: hold rst_n_i=0 for 3 cycles, checking out_valid_o=0, in_ready_o=0, count_o=0. Release, then send data_i=3, mode_i=0 with out_ready_i=1. Next cycle: data_o=8'b0000_1000, err_o=0, count_o=1.
- Thermometer: send data_i=5, mode_i=1. Required: data_o=8'b0011_1111. Then send data_i=0, mode_i=1. Required: data_o=8'b0000_0001.
- Back-pressure: send data_i=6, then hold out_ready_i=0 for 4 cycles with in_valid_i=1, data_i=2.
  - During the stall: data_o stays 8'b0100_0000 and in_ready_o=0.
  - After out_ready_i returns to 1: the next result is 8'b0000_0100 and count_o advances by exactly 2 in total.
- Full throughput: present in_valid_i=1 every cycle with data_i=0..7 and out_ready_i=1. Required: 8 consecutive valid outputs 0x01, 0x02, ..., 0x80 with no bubbles.
- Out-of-range: with OUT_W=6, send data_i=7 in both modes. Required: data_o=0, err_o=1, and the transfer is counted.
- Counter wrap and mid-reset: with CNT_W=3, do 9 accepts and check count_o=1. Then assert rst_n_i during a stalled valid output. Required: out_valid_o drops immediately (asynchronously), and count_o=0.

Source files
------------

// File: rtl/decoder_pkg.sv
// Shared definitions for the pipelined binary-to-one-hot / thermometer decoder.
package decoder_pkg;

  // Decode mode encodings, sampled together with the index.
  localparam logic DEC_ONEHOT = 1'b0;
  localparam logic DEC_THERMO = 1'b1;

  // Default widths used by the decoder blocks.
  localparam int DEF_IN_W  = 3;
  localparam int DEF_OUT_W = 8;
  localparam int DEF_CNT_W = 16;

endpackage : decoder_pkg

// File: rtl/decoder_core.sv
// Combinational IN_W-to-OUT_W decode: one-hot or thermometer, with an
// out-of-range flag for indices that have no corresponding output bit.
module decoder_core
  import decoder_pkg::*;
#(
  parameter int IN_W  = DEF_IN_W,
  parameter int OUT_W = DEF_OUT_W
) (
  input  logic [IN_W-1:0]  index,
  input  logic             mode,
  output logic [OUT_W-1:0] vec,
  output logic             oob
);

  // Comparisons are done one bit wider than the index so that OUT_W == 2**IN_W
  // is representable and nothing is truncated.
  localparam logic [IN_W:0] LIMIT = (IN_W + 1)'(OUT_W);

  logic [IN_W:0]    idx_ext;
  logic [OUT_W-1:0] onehot_vec;
  logic [OUT_W-1:0] thermo_vec;

  assign idx_ext = {1'b0, index};

  genvar k;
  generate
    for (k = 0; k < OUT_W; k++) begin : g_bit
      localparam logic [IN_W:0] KV = (IN_W + 1)'(k);
      assign onehot_vec[k] = (idx_ext == KV);
      assign thermo_vec[k] = (KV <= idx_ext);
    end
  endgenerate

  // Select the decode style; an out-of-range index always yields an all-zero vector.
  always_comb begin
    oob = (idx_ext >= LIMIT);
    vec = '0;
    if (oob) begin
      vec = '0;
    end else begin
      case (mode)
        DEC_ONEHOT: vec = onehot_vec;
        DEC_THERMO: vec = thermo_vec;
        default:    vec = '0;
      endcase
    end
  end

endmodule : decoder_core

// File: rtl/decoder_pipe.sv
// Registered decoder with valid/ready on both sides and an accepted-transfer
// counter. A single output register gives full throughput: a new index is
// taken whenever the register is empty or being drained in the same cycle.
module decoder_pipe
  import decoder_pkg::*;
#(
  parameter int IN_W  = DEF_IN_W,
  parameter int OUT_W = DEF_OUT_W,
  parameter int CNT_W = DEF_CNT_W
) (
  input  logic             clk_i,
  input  logic             rst_n_i,
  input  logic             in_valid_i,
  output logic             in_ready_o,
  input  logic [IN_W-1:0]  data_i,
  input  logic             mode_i,
  output logic             out_valid_o,
  input  logic             out_ready_i,
  output logic [OUT_W-1:0] data_o,
  output logic             err_o,
  output logic [CNT_W-1:0] count_o
);

  logic [OUT_W-1:0] dec_vec;
  logic             dec_oob;
  logic             accept;

  logic             valid_r;
  logic [OUT_W-1:0] data_r;
  logic             err_r;
  logic [CNT_W-1:0] count_r;

  decoder_core #(
    .IN_W  (IN_W),
    .OUT_W (OUT_W)
  ) u_core (
    .index (data_i),
    .mode  (mode_i),
    .vec   (dec_vec),
    .oob   (dec_oob)
  );

  // Ready is held low during reset so nothing is taken while the block is cleared.
  assign in_ready_o = rst_n_i & (~valid_r | out_ready_i);
  assign accept     = in_valid_i & in_ready_o;

  // Output register: load on accept, empty on drain, hold while stalled.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      valid_r <= 1'b0;
      data_r  <= '0;
      err_r   <= 1'b0;
      count_r <= '0;
    end else if (accept) begin
      valid_r <= 1'b1;
      data_r  <= dec_vec;
      err_r   <= dec_oob;
      count_r <= count_r + CNT_W'(1);
    end else if (out_ready_i) begin
      valid_r <= 1'b0;
      data_r  <= data_r;
      err_r   <= err_r;
      count_r <= count_r;
    end else begin
      valid_r <= valid_r;
      data_r  <= data_r;
      err_r   <= err_r;
      count_r <= count_r;
    end
  end

  assign out_valid_o = valid_r;
  assign data_o      = data_r;
  assign err_o       = err_r;
  assign count_o     = count_r;

endmodule : decoder_pipe

// File: tb/tb_decoder_pipe.sv
// Directed bench for decoder_pipe: three instances share one stimulus stream
// (default widths, OUT_W=6 for out-of-range indices, CNT_W=3 for wrap).
module tb_decoder_pipe;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       in_valid;
  logic [2:0] data;
  logic       mode;
  logic       out_ready;

  logic       a_in_ready, a_out_valid, a_err;
  logic [7:0] a_data;
  logic [15:0] a_count;

  logic       b_in_ready, b_out_valid, b_err;
  logic [5:0] b_data;
  logic [15:0] b_count;

  logic       c_in_ready, c_out_valid, c_err;
  logic [7:0] c_data;
  logic [2:0] c_count;

  int tests_run = 0;
  int tests_failed = 0;

  always #5 clk = ~clk;

  decoder_pipe u_dut (
    .clk_i(clk), .rst_n_i(rst_n), .in_valid_i(in_valid), .in_ready_o(a_in_ready),
    .data_i(data), .mode_i(mode), .out_valid_o(a_out_valid), .out_ready_i(out_ready),
    .data_o(a_data), .err_o(a_err), .count_o(a_count)
  );

  decoder_pipe #(.IN_W(3), .OUT_W(6), .CNT_W(16)) u_oob (
    .clk_i(clk), .rst_n_i(rst_n), .in_valid_i(in_valid), .in_ready_o(b_in_ready),
    .data_i(data), .mode_i(mode), .out_valid_o(b_out_valid), .out_ready_i(out_ready),
    .data_o(b_data), .err_o(b_err), .count_o(b_count)
  );

  decoder_pipe #(.IN_W(3), .OUT_W(8), .CNT_W(3)) u_cnt (
    .clk_i(clk), .rst_n_i(rst_n), .in_valid_i(in_valid), .in_ready_o(c_in_ready),
    .data_i(data), .mode_i(mode), .out_valid_o(c_out_valid), .out_ready_i(out_ready),
    .data_o(c_data), .err_o(c_err), .count_o(c_count)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests_run++;
    assert (obs === exp) else begin
      tests_failed++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n = 1'b0; in_valid = 1'b0; data = 3'd0; mode = 1'b0; out_ready = 1'b1;

    // Reset held for three cycles
    for (int i = 0; i < 3; i++) begin
      tick();
      check("rst_valid", 32'(a_out_valid), 32'd0);
      check("rst_ready", 32'(a_in_ready), 32'd0);
      check("rst_count", 32'(a_count), 32'd0);
    end
    rst_n = 1'b1;
    #1;
    check("ready_after_rst", 32'(a_in_ready), 32'd1);

    // One-hot index 3
    in_valid = 1'b1; data = 3'd3; mode = 1'b0;
    tick();
    in_valid = 1'b0;
    check("oh3_valid", 32'(a_out_valid), 32'd1);
    check("oh3_data", 32'(a_data), 32'h08);
    check("oh3_err", 32'(a_err), 32'd0);
    check("oh3_count", 32'(a_count), 32'd1);
    tick();
    check("drain_valid", 32'(a_out_valid), 32'd0);

    // Thermometer 5 then 0, back to back
    in_valid = 1'b1; data = 3'd5; mode = 1'b1;
    tick();
    check("th5_data", 32'(a_data), 32'h3F);
    data = 3'd0;
    tick();
    in_valid = 1'b0;
    check("th0_data", 32'(a_data), 32'h01);
    check("th0_count", 32'(a_count), 32'd3);
    tick();

    // Back-pressure: index 6 held while index 2 waits
    in_valid = 1'b1; data = 3'd6; mode = 1'b0;
    tick();
    check("bp6_data", 32'(a_data), 32'h40);
    check("bp6_count", 32'(a_count), 32'd4);
    out_ready = 1'b0; data = 3'd2;
    #1;
    check("bp_ready_low", 32'(a_in_ready), 32'd0);
    for (int i = 0; i < 4; i++) begin
      tick();
      check("stall_data", 32'(a_data), 32'h40);
      check("stall_valid", 32'(a_out_valid), 32'd1);
      check("stall_ready", 32'(a_in_ready), 32'd0);
      check("stall_count", 32'(a_count), 32'd4);
    end
    out_ready = 1'b1;
    #1;
    check("bp_ready_back", 32'(a_in_ready), 32'd1);
    tick();
    in_valid = 1'b0;
    check("bp2_data", 32'(a_data), 32'h04);
    check("bp2_valid", 32'(a_out_valid), 32'd1);
    check("bp2_count", 32'(a_count), 32'd5);
    tick();
    check("bp_drain", 32'(a_out_valid), 32'd0);

    // Full throughput, one-hot 0..7 with no bubbles
    in_valid = 1'b1; mode = 1'b0;
    for (int i = 0; i < 8; i++) begin
      data = 3'(i);
      tick();
      check("ft_valid", 32'(a_out_valid), 32'd1);
      check("ft_data", 32'(a_data), 32'd1 << i);
    end
    check("ft_count", 32'(a_count), 32'd13);

    // Out-of-range on the OUT_W=6 instance, plus in-range boundary
    data = 3'd7; mode = 1'b0;
    tick();
    check("oob7_oh_data", 32'(b_data), 32'd0);
    check("oob7_oh_err", 32'(b_err), 32'd1);
    check("full7_oh_err", 32'(a_err), 32'd0);
    check("full7_oh_data", 32'(a_data), 32'h80);
    data = 3'd7; mode = 1'b1;
    tick();
    check("oob7_th_data", 32'(b_data), 32'd0);
    check("oob7_th_err", 32'(b_err), 32'd1);
    check("full7_th_data", 32'(a_data), 32'hFF);
    data = 3'd5; mode = 1'b1;
    tick();
    check("in5_th_data", 32'(b_data), 32'h3F);
    check("in5_th_err", 32'(b_err), 32'd0);
    data = 3'd6; mode = 1'b0;
    tick();
    in_valid = 1'b0;
    check("oob6_data", 32'(b_data), 32'd0);
    check("oob6_err", 32'(b_err), 32'd1);
    check("oob_count", 32'(b_count), 32'd17);
    tick();

    // Counter wrap: fresh reset, nine accepts
    rst_n = 1'b0;
    #1;
    check("rst2_valid", 32'(c_out_valid), 32'd0);
    check("rst2_count", 32'(c_count), 32'd0);
    tick();
    rst_n = 1'b1;
    in_valid = 1'b1; data = 3'd1; mode = 1'b0;
    for (int i = 0; i < 9; i++) tick();
    in_valid = 1'b0; out_ready = 1'b0;
    check("wrap_count", 32'(c_count), 32'd1);
    check("nowrap_count", 32'(a_count), 32'd9);
    tick();
    check("wrap_stall_valid", 32'(c_out_valid), 32'd1);
    check("wrap_stall_data", 32'(c_data), 32'h02);

    // Asynchronous reset mid-cycle during a stall
    #3;
    rst_n = 1'b0;
    #1;
    check("arst_valid", 32'(c_out_valid), 32'd0);
    check("arst_count", 32'(c_count), 32'd0);
    check("arst_data", 32'(c_data), 32'd0);
    check("arst_ready", 32'(c_in_ready), 32'd0);
    check("arst_valid_a", 32'(a_out_valid), 32'd0);
    tick();
    rst_n = 1'b1; out_ready = 1'b1;
    #1;
    check("arst_release_ready", 32'(c_in_ready), 32'd1);
    tick();

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule : tb_decoder_pipe
